// File: rtl/controle_lavagem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : controle_lavagem                                              |
// | Purpose  : Wash-cycle sequencer of the washing machine. Runs             |
// |            fill -> wash -> drain -> refill -> rinse -> drain, then holds |
// |            iniciar_centrif high and watches the centrifugar pulse train  |
// |            of the downstream spin stage to detect the end of the spin.   |
// | Ports    : clk, rst (async, active-high)                                 |
// |            ligar, porta_fechada, nivel_cheio, centrifugar  (inputs)      |
// |            valvula_agua, motor_lavar, bomba_esvaziar, iniciar_centrif,   |
// |            ciclo_fim, erro, estado[2:0]                    (registered)  |
// | Options  : TIMEOUT_ENCHER_EN - enables the fill timeout (ENCHER -> ERRO  |
// |            after T_ENCHER_MAX unpaused cycles without nivel_cheio).      |
// |            Undefined: fill waits forever, erro is constant 0.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module controle_lavagem #(
   parameter int unsigned T_LAVAR      = 20,
   parameter int unsigned T_ENXAGUAR   = 10,
   parameter int unsigned T_ESVAZIAR   = 15,
   parameter int unsigned T_ENCHER_MAX = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ligar,
   input  logic       porta_fechada,
   input  logic       nivel_cheio,
   input  logic       centrifugar,
   output logic       valvula_agua,
   output logic       motor_lavar,
   output logic       bomba_esvaziar,
   output logic       iniciar_centrif,
   output logic       ciclo_fim,
   output logic       erro,
   output logic [2:0] estado
);

   typedef enum logic [2:0] {
      REPOUSO     = 3'd0,
      ENCHER      = 3'd1,
      LAVAR       = 3'd2,
      ESVAZIAR    = 3'd3,
      ENXAGUAR    = 3'd4,
      CENTRIFUGAR = 3'd5,
      FIM         = 3'd6,
      ERRO        = 3'd7
   } estado_t;

`ifdef TIMEOUT_ENCHER_EN
   localparam bit c_timeout_en = 1'b1;
`else
   localparam bit c_timeout_en = 1'b0;
`endif

   // Terminal counts: a timed state leaves on the edge where tempo == T-1.
   localparam logic [7:0] c_lavar_fim    = 8'(T_LAVAR - 1);
   localparam logic [7:0] c_enxaguar_fim = 8'(T_ENXAGUAR - 1);
   localparam logic [7:0] c_esvaziar_fim = 8'(T_ESVAZIAR - 1);
   localparam logic [7:0] c_encher_fim   = 8'(T_ENCHER_MAX - 1);

   estado_t    r_estado;
   estado_t    w_prox;
   logic [7:0] r_tempo;
   logic [7:0] w_tempo;
   logic       r_enxague;
   logic       w_enxague;
   logic       r_visto;
   logic       w_visto;
   logic       w_pausa;
   logic       r_valvula;
   logic       r_motor;
   logic       r_bomba;
   logic       r_iniciar;
   logic       r_fim;
   logic       r_erro;

   // Next-state logic. The door pause only applies to the active states
   // (ENCHER..CENTRIFUGAR): the state and tempo are held and the actuators
   // are dropped on the same edge.
   always_comb begin
      w_prox    = r_estado;
      w_tempo   = r_tempo;
      w_enxague = r_enxague;
      w_visto   = r_visto;
      w_pausa   = 1'b0;

      case (r_estado)
         REPOUSO: begin
            if (ligar && porta_fechada) begin
               w_prox    = ENCHER;
               w_enxague = 1'b0;
            end
         end

         FIM: w_prox = REPOUSO;

         ERRO: w_prox = ERRO;

         default: begin
            if (!porta_fechada) begin
               w_pausa = 1'b1;
               // Dropping iniciar_centrif resets the spin stage, so any
               // pulses already seen no longer count.
               if (r_estado == CENTRIFUGAR) begin
                  w_visto = 1'b0;
               end
            end else begin
               case (r_estado)
                  ENCHER: begin
                     if (nivel_cheio) begin
                        w_prox = r_enxague ? ENXAGUAR : LAVAR;
                     end else if (c_timeout_en && (r_tempo == c_encher_fim)) begin
                        w_prox = ERRO;
                     end else begin
                        w_tempo = r_tempo + 8'd1;
                     end
                  end
                  LAVAR: begin
                     if (r_tempo == c_lavar_fim) w_prox = ESVAZIAR;
                     else                        w_tempo = r_tempo + 8'd1;
                  end
                  ENXAGUAR: begin
                     if (r_tempo == c_enxaguar_fim) w_prox = ESVAZIAR;
                     else                           w_tempo = r_tempo + 8'd1;
                  end
                  ESVAZIAR: begin
                     if (r_tempo == c_esvaziar_fim) begin
                        if (!r_enxague) begin
                           w_prox    = ENCHER;
                           w_enxague = 1'b1;
                        end else begin
                           w_prox = CENTRIFUGAR;
                        end
                     end else begin
                        w_tempo = r_tempo + 8'd1;
                     end
                  end
                  CENTRIFUGAR: begin
                     // End of spin: the pulse train stops after having started.
                     if (centrifugar)  w_visto = 1'b1;
                     else if (r_visto) w_prox  = FIM;
                  end
                  default: w_prox = r_estado;
               endcase
            end
         end
      endcase

      if (w_prox != r_estado) begin
         w_tempo = 8'd0;
         if (w_prox == CENTRIFUGAR) begin
            w_visto = 1'b0;
         end
      end
   end

   // State and outputs share one register stage, so the outputs always
   // describe the state being entered on this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_estado  <= REPOUSO;
         r_tempo   <= 8'd0;
         r_enxague <= 1'b0;
         r_visto   <= 1'b0;
         r_valvula <= 1'b0;
         r_motor   <= 1'b0;
         r_bomba   <= 1'b0;
         r_iniciar <= 1'b0;
         r_fim     <= 1'b0;
         r_erro    <= 1'b0;
      end else begin
         r_estado  <= w_prox;
         r_tempo   <= w_tempo;
         r_enxague <= w_enxague;
         r_visto   <= w_visto;
         r_valvula <= (w_prox == ENCHER) && !w_pausa;
         r_motor   <= ((w_prox == LAVAR) || (w_prox == ENXAGUAR)) && !w_pausa;
         r_bomba   <= ((w_prox == ESVAZIAR) || (w_prox == CENTRIFUGAR)) && !w_pausa;
         r_iniciar <= (w_prox == CENTRIFUGAR) && !w_pausa;
         r_fim     <= (w_prox == FIM);
         r_erro    <= c_timeout_en && (w_prox == ERRO);
      end
   end

   assign valvula_agua    = r_valvula;
   assign motor_lavar     = r_motor;
   assign bomba_esvaziar  = r_bomba;
   assign iniciar_centrif = r_iniciar;
   assign ciclo_fim       = r_fim;
   assign erro            = r_erro;
   assign estado          = r_estado;

endmodule
`default_nettype wire
